// File: rtl/note_seq_pkg.sv
// Shared types for the programmable note-sequence matcher: note codes,
// slot match modes, FSM states and the stored slot record.
package note_seq_pkg;

  // Widest note code a slot can hold; NOTE_W of the matcher must not exceed it.
  localparam int NOTE_MAX_W = 8;
  typedef logic [NOTE_MAX_W-1:0] note_t;

  localparam logic [2:0] NOTE_X = 3'b000;
  localparam logic [2:0] NOTE_C = 3'b100;
  localparam logic [2:0] NOTE_D = 3'b010;
  localparam logic [2:0] NOTE_E = 3'b110;
  localparam logic [2:0] NOTE_F = 3'b001;
  localparam logic [2:0] NOTE_G = 3'b101;
  localparam logic [2:0] NOTE_A = 3'b011;
  localparam logic [2:0] NOTE_B = 3'b111;

  typedef enum logic [1:0] {
    MODE_EXACT     = 2'd0,
    MODE_ANY_NOTE  = 2'd1,
    MODE_REST      = 2'd2,
    MODE_DONT_CARE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_MATCHED = 2'd1,
    ST_FAILED  = 2'd2
  } state_e;

  typedef struct packed {
    mode_e mode;
    logic  tone;
    note_t note;
  } slot_t;

endpackage

// File: rtl/note_slot_cmp.sv
// Combinational match of one live (tone, note) entry against one stored slot.
module note_slot_cmp
  import note_seq_pkg::*;
#(
  parameter int NOTE_W = 3
) (
  input  slot_t             slot,
  input  logic              tone,
  input  logic [NOTE_W-1:0] note,
  output logic              hit
);

  always_comb begin
    hit = 1'b1;
    case (slot.mode)
      MODE_EXACT:     hit = (tone == slot.tone) && (note_t'(note) == slot.note);
      MODE_ANY_NOTE:  hit = (note != '0);
      MODE_REST:      hit = (note == '0);
      default:        hit = 1'b1;
    endcase
  end

endmodule

// File: rtl/note_seq_matcher.sv
// Races N_PAT programmable note patterns against entries committed on the
// falling edge of ok; reports the lowest-index survivor, a mismatch or a timeout.
module note_seq_matcher
  import note_seq_pkg::*;
#(
  parameter int  SEQ_LEN     = 6,
  parameter int  N_PAT       = 3,
  parameter int  NOTE_W      = 3,
  parameter int  TIMEOUT_CYC = 0,
  localparam int PAT_W       = (N_PAT > 1) ? $clog2(N_PAT) : 1,
  localparam int SLOT_W      = $clog2(SEQ_LEN),
  localparam int POS_W       = $clog2(SEQ_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              ok,
  input  logic              tone,
  input  logic [NOTE_W-1:0] note,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pat,
  input  logic [SLOT_W-1:0] cfg_pos,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_tone,
  input  logic [NOTE_W-1:0] cfg_note,
  input  logic [N_PAT-1:0]  cfg_en,
  output logic              finish,
  output logic              matched,
  output logic [PAT_W-1:0]  match_id,
  output logic              timeout,
  output logic [POS_W-1:0]  pos,
  output logic              busy
);

  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_e             state;
  logic               prev_ok;
  logic [N_PAT-1:0]   alive;
  logic [N_PAT-1:0]   en_r;
  logic [TMR_W-1:0]   timer;
  logic [PAT_W-1:0]   match_id_r;
  slot_t              slots [N_PAT][SEQ_LEN];

  logic               ev;
  logic               expire;
  logic               cfg_ok;
  logic [SLOT_W-1:0]  pos_idx;
  logic [N_PAT-1:0]   hit_vec;
  logic [N_PAT-1:0]   nxt;
  logic [PAT_W-1:0]   win_id;

  // Handshake: an entry is committed in the cycle ok goes 1->0; tone/note are
  // sampled in that same cycle and the result is visible one clock later.
  assign ev      = prev_ok & ~ok;
  assign busy    = (state == ST_COLLECT) && (pos != '0);
  assign pos_idx = pos[SLOT_W-1:0];
  assign nxt     = alive & en_r & hit_vec;
  assign expire  = (TIMEOUT_CYC != 0) && busy && !ev &&
                   (timer == TMR_W'(TIMEOUT_CYC - 1));
  assign cfg_ok  = cfg_we && !busy &&
                   ({1'b0, cfg_pat} < (PAT_W + 1)'(N_PAT)) &&
                   ({1'b0, cfg_pos} < (SLOT_W + 1)'(SEQ_LEN));

  for (genvar p = 0; p < N_PAT; p++) begin : g_cmp
    note_slot_cmp #(.NOTE_W(NOTE_W)) u_cmp (
      .slot (slots[p][pos_idx]),
      .tone (tone),
      .note (note),
      .hit  (hit_vec[p])
    );
  end

  always_comb begin
    win_id = '0;
    for (int p = N_PAT - 1; p >= 0; p--) begin
      if (nxt[p]) win_id = PAT_W'(p);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_COLLECT;
      pos        <= '0;
      prev_ok    <= 1'b0;
      alive      <= '1;
      en_r       <= '0;
      timer      <= '0;
      match_id_r <= '0;
      timeout    <= 1'b0;
    end else begin
      prev_ok <= ok;
      if (!busy) en_r <= cfg_en;
      if (clear) begin
        state      <= ST_COLLECT;
        pos        <= '0;
        alive      <= '1;
        timer      <= '0;
        match_id_r <= '0;
        timeout    <= 1'b0;
      end else if (state == ST_COLLECT) begin
        if (ev) begin
          timer <= '0;
          if (nxt == '0) begin
            state <= ST_FAILED;
          end else if (pos == POS_W'(SEQ_LEN - 1)) begin
            state      <= ST_MATCHED;
            pos        <= pos + POS_W'(1);
            match_id_r <= win_id;
          end else begin
            pos   <= pos + POS_W'(1);
            alive <= nxt;
          end
        end else if (expire) begin
          state   <= ST_FAILED;
          timeout <= 1'b1;
        end else if (busy) begin
          timer <= timer + TMR_W'(1);
        end
      end
    end
  end

  // Pattern storage: the ev-cycle compare sees the pre-write contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < N_PAT; p++) begin
        for (int s = 0; s < SEQ_LEN; s++) begin
          slots[p][s] <= '0;
        end
      end
    end else if (cfg_ok) begin
      slots[cfg_pat][cfg_pos] <= '{mode: mode_e'(cfg_mode),
                                   tone: cfg_tone,
                                   note: note_t'(cfg_note)};
    end
  end

  assign finish   = (state != ST_COLLECT);
  assign matched  = (state == ST_MATCHED);
  assign match_id = matched ? match_id_r : '0;

endmodule

// File: tb/tb_note_seq_matcher.sv
// Directed bench for note_seq_matcher: vector table plus hand-written
// sequences for timeout, clear, config-while-busy and async reset.
module tb_note_seq_matcher;
  import note_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       ok = 1'b0;
  logic       tone = 1'b0;
  logic [2:0] note = '0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_pat = '0;
  logic [2:0] cfg_pos = '0;
  logic [1:0] cfg_mode = '0;
  logic       cfg_tone = 1'b0;
  logic [2:0] cfg_note = '0;
  logic [2:0] cfg_en = '0;

  logic       fin0, mat0, to0, busy0;
  logic [1:0] id0;
  logic [2:0] pos0;
  logic       fin1, mat1, to1, busy1;
  logic [1:0] id1;
  logic [2:0] pos1;

  int n_checks = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];

  note_seq_matcher #(.SEQ_LEN(6), .N_PAT(3), .NOTE_W(3), .TIMEOUT_CYC(0)) dut0 (
    .clk(clk), .reset(reset), .clear(clear), .ok(ok), .tone(tone), .note(note),
    .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_pos(cfg_pos), .cfg_mode(cfg_mode),
    .cfg_tone(cfg_tone), .cfg_note(cfg_note), .cfg_en(cfg_en),
    .finish(fin0), .matched(mat0), .match_id(id0), .timeout(to0), .pos(pos0), .busy(busy0)
  );

  note_seq_matcher #(.SEQ_LEN(6), .N_PAT(3), .NOTE_W(3), .TIMEOUT_CYC(10)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .ok(ok), .tone(tone), .note(note),
    .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_pos(cfg_pos), .cfg_mode(cfg_mode),
    .cfg_tone(cfg_tone), .cfg_note(cfg_note), .cfg_en(cfg_en),
    .finish(fin1), .matched(mat1), .match_id(id1), .timeout(to1), .pos(pos1), .busy(busy1)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  function automatic logic [8:0] ew(input logic f, input logic m, input logic [1:0] id,
                                    input logic t, input logic [2:0] p, input logic b);
    return {f, m, id, t, p, b};
  endfunction

  function automatic logic [8:0] obs0();
    return {fin0, mat0, id0, to0, pos0, busy0};
  endfunction

  function automatic logic [8:0] obs1();
    return {fin1, mat1, id1, to1, pos1, busy1};
  endfunction

  // Scoreboard: expected value goes through exp_q, compared against the DUT.
  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    logic [8:0] e;
    exp_q.push_back(exp);
    e = exp_q.pop_front();
    n_checks++;
    if (act !== e) begin
      n_err++;
      $display("FAIL %s: got f/m/id/to/pos/busy=%b expected %b", name, act, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic pulse(input logic t, input logic [2:0] n);
    tone = t;
    note = n;
    ok = 1'b1;
    tick();
    ok = 1'b0;
    tick();
  endtask

  task automatic wr(input int p, input int s, input mode_e m, input logic t, input logic [2:0] n);
    cfg_we = 1'b1;
    cfg_pat = 2'(p);
    cfg_pos = 3'(s);
    cfg_mode = m;
    cfg_tone = t;
    cfg_note = n;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic program_base();
    for (int p = 0; p < 3; p++) begin
      wr(p, 0, MODE_EXACT, 1'b0, NOTE_F);
      wr(p, 2, MODE_ANY_NOTE, 1'b0, NOTE_X);
      wr(p, 3, MODE_ANY_NOTE, 1'b0, NOTE_X);
      wr(p, 4, MODE_EXACT, 1'b0, NOTE_G);
      wr(p, 5, MODE_REST, 1'b0, NOTE_X);
    end
    wr(0, 1, MODE_EXACT, 1'b1, NOTE_C);
    wr(1, 1, MODE_EXACT, 1'b1, NOTE_F);
    wr(2, 1, MODE_EXACT, 1'b1, NOTE_B);
  endtask

  task automatic run_seq1();
    pulse(1'b0, NOTE_F);
    pulse(1'b1, NOTE_F);
    pulse(1'b0, NOTE_D);
    pulse(1'b1, NOTE_A);
    pulse(1'b0, NOTE_G);
    pulse(1'b0, NOTE_X);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         clr;
    logic       tone;
    logic [2:0] note;
    logic [8:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input bit c, input logic t, input logic [2:0] n,
                               input logic [8:0] e, input string nm);
    vec_t v;
    v.clr = c; v.tone = t; v.note = n; v.exp = e; v.name = nm;
    return v;
  endfunction

  initial begin
    // scenario 1: p1 wins
    vecs.push_back(mkv(1, 0, NOTE_F, ew(0, 0, 0, 0, 1, 1), "s1_n1"));
    vecs.push_back(mkv(0, 1, NOTE_F, ew(0, 0, 0, 0, 2, 1), "s1_n2"));
    vecs.push_back(mkv(0, 0, NOTE_D, ew(0, 0, 0, 0, 3, 1), "s1_n3"));
    vecs.push_back(mkv(0, 1, NOTE_A, ew(0, 0, 0, 0, 4, 1), "s1_n4"));
    vecs.push_back(mkv(0, 0, NOTE_G, ew(0, 0, 0, 0, 5, 1), "s1_n5"));
    vecs.push_back(mkv(0, 0, NOTE_X, ew(1, 1, 1, 0, 6, 0), "s1_match"));
    vecs.push_back(mkv(0, 1, NOTE_F, ew(1, 1, 1, 0, 6, 0), "matched_ignores_ev"));
    // scenario 2: mismatch on slot 1
    vecs.push_back(mkv(1, 0, NOTE_F, ew(0, 0, 0, 0, 1, 1), "s2_n1"));
    vecs.push_back(mkv(0, 1, NOTE_E, ew(1, 0, 0, 0, 1, 0), "s2_fail"));
    // exact tone mismatch on the first slot
    vecs.push_back(mkv(1, 1, NOTE_F, ew(1, 0, 0, 0, 0, 0), "tone_fail_pos0"));
    // ANY_NOTE rejects a rest
    vecs.push_back(mkv(1, 0, NOTE_F, ew(0, 0, 0, 0, 1, 1), "any_n1"));
    vecs.push_back(mkv(0, 1, NOTE_F, ew(0, 0, 0, 0, 2, 1), "any_n2"));
    vecs.push_back(mkv(0, 0, NOTE_X, ew(1, 0, 0, 0, 2, 0), "any_rest_fail"));
    // REST rejects a note on the last slot
    vecs.push_back(mkv(1, 0, NOTE_F, ew(0, 0, 0, 0, 1, 1), "rest_n1"));
    vecs.push_back(mkv(0, 1, NOTE_B, ew(0, 0, 0, 0, 2, 1), "rest_n2"));
    vecs.push_back(mkv(0, 1, NOTE_C, ew(0, 0, 0, 0, 3, 1), "rest_n3"));
    vecs.push_back(mkv(0, 0, NOTE_E, ew(0, 0, 0, 0, 4, 1), "rest_n4"));
    vecs.push_back(mkv(0, 0, NOTE_G, ew(0, 0, 0, 0, 5, 1), "rest_n5"));
    vecs.push_back(mkv(0, 0, NOTE_C, ew(1, 0, 0, 0, 5, 0), "rest_last_fail"));
    // p2 completes alone
    vecs.push_back(mkv(1, 0, NOTE_F, ew(0, 0, 0, 0, 1, 1), "p2_n1"));
    vecs.push_back(mkv(0, 1, NOTE_B, ew(0, 0, 0, 0, 2, 1), "p2_n2"));
    vecs.push_back(mkv(0, 0, NOTE_D, ew(0, 0, 0, 0, 3, 1), "p2_n3"));
    vecs.push_back(mkv(0, 0, NOTE_D, ew(0, 0, 0, 0, 4, 1), "p2_n4"));
    vecs.push_back(mkv(0, 0, NOTE_G, ew(0, 0, 0, 0, 5, 1), "p2_n5"));
    vecs.push_back(mkv(0, 0, NOTE_X, ew(1, 1, 2, 0, 6, 0), "p2_match"));

    // ---------------- reset ----------------
    tick();
    tick();
    check("reset_outputs_dut0", obs0(), ew(0, 0, 0, 0, 0, 0));
    check("reset_outputs_dut1", obs1(), ew(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;
    tick();

    cfg_en = 3'b111;
    program_base();

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      if (vecs[i].clr) do_clear();
      pulse(vecs[i].tone, vecs[i].note);
      check(vecs[i].name, obs0(), vecs[i].exp);
    end

    // ---------------- timeout ----------------
    do_clear();
    pulse(1'b0, NOTE_F);
    ok = 1'b1;
    repeat (9) tick();
    check("tmo_not_yet", obs1(), ew(0, 0, 0, 0, 1, 1));
    tick();
    check("tmo_expired", obs1(), ew(1, 0, 0, 1, 1, 0));
    check("tmo_disabled", obs0(), ew(0, 0, 0, 0, 1, 1));
    do_clear();
    pulse(1'b0, NOTE_F);
    ok = 1'b1;
    repeat (9) tick();
    tone = 1'b1;
    note = NOTE_F;
    ok = 1'b0;
    tick();
    check("tmo_ev_wins", obs1(), ew(0, 0, 0, 0, 2, 1));
    repeat (9) tick();
    check("tmo_timer_restart", obs1(), ew(0, 0, 0, 0, 2, 1));
    tick();
    check("tmo_second_expiry", obs1(), ew(1, 0, 0, 1, 2, 0));

    // ---------------- DONT_CARE / lowest index ----------------
    do_clear();
    wr(0, 1, MODE_DONT_CARE, 1'b0, NOTE_X);
    wr(2, 1, MODE_DONT_CARE, 1'b0, NOTE_X);
    run_seq1();
    check("dc_lowest_wins", obs0(), ew(1, 1, 0, 0, 6, 0));
    do_clear();
    pulse(1'b0, NOTE_F);
    pulse(1'b0, NOTE_X);
    pulse(1'b0, NOTE_D);
    pulse(1'b1, NOTE_A);
    pulse(1'b0, NOTE_G);
    pulse(1'b0, NOTE_X);
    check("dc_rest_slot", obs0(), ew(1, 1, 0, 0, 6, 0));
    cfg_en = 3'b110;
    do_clear();
    pulse(1'b0, NOTE_F);
    pulse(1'b0, NOTE_X);
    pulse(1'b0, NOTE_D);
    pulse(1'b1, NOTE_A);
    pulse(1'b0, NOTE_G);
    pulse(1'b0, NOTE_X);
    check("dc_p0_disabled", obs0(), ew(1, 1, 2, 0, 6, 0));
    cfg_en = 3'b111;

    // ---------------- config write while busy is dropped ----------------
    do_clear();
    pulse(1'b0, NOTE_F);
    pulse(1'b1, NOTE_F);
    pulse(1'b0, NOTE_D);
    check("busy_pos3", obs0(), ew(0, 0, 0, 0, 3, 1));
    wr(0, 0, MODE_EXACT, 1'b1, NOTE_B);
    do_clear();
    run_seq1();
    check("busy_write_dropped", obs0(), ew(1, 1, 0, 0, 6, 0));

    // ---------------- write and ev together at pos 0 ----------------
    cfg_en = 3'b001;
    do_clear();
    tone = 1'b0;
    note = NOTE_F;
    ok = 1'b1;
    tick();
    ok = 1'b0;
    cfg_we = 1'b1;
    cfg_pat = 2'd0;
    cfg_pos = 3'd0;
    cfg_mode = MODE_EXACT;
    cfg_tone = 1'b1;
    cfg_note = NOTE_B;
    tick();
    cfg_we = 1'b0;
    check("prewrite_compare", obs0(), ew(0, 0, 0, 0, 1, 1));
    do_clear();
    pulse(1'b0, NOTE_F);
    check("prewrite_landed", obs0(), ew(1, 0, 0, 0, 0, 0));
    wr(0, 0, MODE_EXACT, 1'b0, NOTE_F);
    cfg_en = 3'b111;

    // ---------------- clear beats ev ----------------
    do_clear();
    pulse(1'b0, NOTE_F);
    pulse(1'b1, NOTE_F);
    ok = 1'b1;
    tick();
    ok = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_beats_ev", obs0(), ew(0, 0, 0, 0, 0, 0));
    pulse(1'b0, NOTE_F);
    check("after_clear_n1", obs0(), ew(0, 0, 0, 0, 1, 1));

    // ---------------- async reset mid-sequence ----------------
    do_clear();
    pulse(1'b0, NOTE_F);
    pulse(1'b1, NOTE_F);
    pulse(1'b0, NOTE_D);
    pulse(1'b1, NOTE_A);
    check("pre_reset_pos4", obs0(), ew(0, 0, 0, 0, 4, 1));
    #3;
    reset = 1'b0;
    #1;
    check("async_reset_dut0", obs0(), ew(0, 0, 0, 0, 0, 0));
    check("async_reset_dut1", obs1(), ew(0, 0, 0, 0, 0, 0));
    #1;
    reset = 1'b1;
    pulse(1'b0, NOTE_F);
    check("post_reset_fail", obs0(), ew(1, 0, 0, 0, 0, 0));
    do_clear();
    pulse(1'b0, NOTE_X);
    check("post_reset_storage_zero", obs0(), ew(0, 0, 0, 0, 1, 1));

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
